// File: rtl/load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | load_store_unit: request/grant data-memory bus master with load extension  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_we,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  output logic        lsu_busy,
  output logic [31:0] dmem_out,
  output logic        wb_valid,
  output logic        lsu_fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]  state_q,  state_d;
  logic        we_q,     we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  lo_q,     lo_d;
  logic [31:0] addr_q,   addr_d;
  logic [3:0]  be_q,     be_d;
  logic [31:0] wdata_q,  wdata_d;
  logic [31:0] dmem_q,   dmem_d;
  logic        wb_q,     wb_d;
  logic        fault_q,  fault_d;
  logic        busy_q,   busy_d;
  logic        req_q,    req_d;
  logic        mwe_q,    mwe_d;

  logic        legal;
  logic        aligned;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] lane;
  logic [31:0] ext;

  always_comb begin
    legal = 1'b0;
    if (ex_we) begin
      case (ex_funct3)
        3'd0, 3'd1, 3'd2: legal = 1'b1;
        default:          legal = 1'b0;
      endcase
    end else begin
      case (ex_funct3)
        3'd0, 3'd1, 3'd2, 3'd4, 3'd5: legal = 1'b1;
        default:                      legal = 1'b0;
      endcase
    end

    // funct3[1:0] encodes access size for both loads and stores
    case (ex_funct3[1:0])
      2'b00: begin
        aligned    = 1'b1;
        be_calc    = 4'b0001 << ex_addr[1:0];
        wdata_calc = {4{ex_wdata[7:0]}};
      end
      2'b01: begin
        aligned    = ~ex_addr[0];
        be_calc    = 4'b0011 << ex_addr[1:0];
        wdata_calc = {2{ex_wdata[15:0]}};
      end
      2'b10: begin
        aligned    = (ex_addr[1:0] == 2'b00);
        be_calc    = 4'b1111;
        wdata_calc = ex_wdata;
      end
      default: begin
        aligned    = 1'b0;
        be_calc    = 4'b1111;
        wdata_calc = ex_wdata;
      end
    endcase
  end

  always_comb begin
    lane = mem_rdata >> {lo_q, 3'b000};
    case (funct3_q)
      3'd0:    ext = {{24{lane[7]}}, lane[7:0]};
      3'd1:    ext = {{16{lane[15]}}, lane[15:0]};
      3'd4:    ext = {24'd0, lane[7:0]};
      3'd5:    ext = {16'd0, lane[15:0]};
      default: ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    lo_d     = lo_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    dmem_d   = dmem_q;
    wb_d     = 1'b0;
    fault_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ex_valid) begin
          if (legal && aligned) begin
            we_d     = ex_we;
            funct3_d = ex_funct3;
            lo_d     = ex_addr[1:0];
            addr_d   = {ex_addr[31:2], 2'b00};
            be_d     = be_calc;
            wdata_d  = wdata_calc;
            state_d  = S_REQ;
          end else begin
            fault_d  = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (mem_gnt) begin
          if (we_q) begin
            wb_d    = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          dmem_d  = ext;
          wb_d    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    req_d  = (state_d == S_REQ);
    mwe_d  = (state_d == S_REQ) && we_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      lo_q     <= 2'd0;
      addr_q   <= 32'd0;
      be_q     <= 4'd0;
      wdata_q  <= 32'd0;
      dmem_q   <= 32'd0;
      wb_q     <= 1'b0;
      fault_q  <= 1'b0;
      busy_q   <= 1'b0;
      req_q    <= 1'b0;
      mwe_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      lo_q     <= lo_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      dmem_q   <= dmem_d;
      wb_q     <= wb_d;
      fault_q  <= fault_d;
      busy_q   <= busy_d;
      req_q    <= req_d;
      mwe_q    <= mwe_d;
    end
  end

  assign lsu_busy  = busy_q;
  assign dmem_out  = dmem_q;
  assign wb_valid  = wb_q;
  assign lsu_fault = fault_q;
  assign mem_req   = req_q;
  assign mem_we    = mwe_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_load_store_unit: scoreboard bench for load_store_unit                   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_we = 1'b0;
  logic [2:0]  ex_funct3 = 3'd0;
  logic [31:0] ex_addr = 32'd0;
  logic [31:0] ex_wdata = 32'd0;
  logic        lsu_busy;
  logic [31:0] dmem_out;
  logic        wb_valid;
  logic        lsu_fault;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_we(ex_we),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .lsu_busy(lsu_busy), .dmem_out(dmem_out), .wb_valid(wb_valid),
    .lsu_fault(lsu_fault), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } bus_t;

  typedef struct {
    logic        fault;
    logic [31:0] out;
    int          cyc;
  } res_t;

  bus_t bus_q[$];
  res_t res_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [31:0] model_dmem = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bus monitor: every request cycle must show the front bus expectation.
  always @(negedge clk) begin
    if (rst_n && mem_req) begin
      if (bus_q.size() == 0) begin
        check("unexpected_req", 32'd1, 32'd0);
      end else begin
        check("mem_addr",  mem_addr,          bus_q[0].addr);
        check("mem_be",    {28'd0, mem_be},   {28'd0, bus_q[0].be});
        check("mem_wdata", mem_wdata,         bus_q[0].wdata);
        check("mem_we",    {31'd0, mem_we},   {31'd0, bus_q[0].we});
        if (mem_gnt) void'(bus_q.pop_front());
      end
    end
  end

  // Result monitor: pulses are matched in order against the result queue.
  always @(negedge clk) begin
    res_t r;
    if (rst_n && (wb_valid || lsu_fault)) begin
      check("pulse_exclusive", {31'd0, wb_valid & lsu_fault}, 32'd0);
      if (res_q.size() == 0) begin
        check("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        r = res_q.pop_front();
        check("pulse_kind",  {31'd0, lsu_fault}, {31'd0, r.fault});
        check("pulse_cycle", cyc, r.cyc);
        check("dmem_out",    dmem_out, r.out);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input int gw, input logic [31:0] rdata,
                        input logic flt, input logic [31:0] exp_out, input logic [31:0] exp_addr,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    int n;
    n = cyc;
    if (flt) begin
      res_q.push_back('{fault: 1'b1, out: model_dmem, cyc: n + 1});
    end else begin
      bus_q.push_back('{addr: exp_addr, be: exp_be, wdata: exp_wdata, we: we});
      if (!we) model_dmem = exp_out;
      res_q.push_back('{fault: 1'b0, out: model_dmem, cyc: n + gw + (we ? 2 : 3)});
    end
    ex_valid = 1'b1; ex_we = we; ex_funct3 = f3; ex_addr = addr; ex_wdata = wdata;
    tick();
    ex_valid = 1'b0;
    if (flt) begin
      check("fault_no_req",  {31'd0, mem_req},  32'd0);
      check("fault_no_busy", {31'd0, lsu_busy}, 32'd0);
    end else begin
      repeat (gw) tick();
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      if (!we) begin
        mem_rvalid = 1'b1; mem_rdata = rdata;
        tick();
        mem_rvalid = 1'b0;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) tick();
    check("rst_busy",  {31'd0, lsu_busy},  32'd0);
    check("rst_req",   {31'd0, mem_req},   32'd0);
    check("rst_wb",    {31'd0, wb_valid},  32'd0);
    check("rst_fault", {31'd0, lsu_fault}, 32'd0);
    check("rst_addr",  mem_addr,           32'd0);
    check("rst_be",    {28'd0, mem_be},    32'd0);
    check("rst_dmem",  dmem_out,           32'd0);
    rst_n = 1'b1;
    tick();

    //     we   f3    addr       wdata         gw rdata         flt exp_out       exp_addr   be       exp_wdata
    run_op(1'b0, 3'd2, 32'h100, 32'h0,        0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 32'h100, 4'b1111, 32'h0);
    run_op(1'b0, 3'd0, 32'h103, 32'h0,        0, 32'h80FF7F01, 0, 32'hFFFFFF80, 32'h100, 4'b1000, 32'h0);
    run_op(1'b0, 3'd4, 32'h103, 32'h0,        1, 32'h80FF7F01, 0, 32'h00000080, 32'h100, 4'b1000, 32'h0);
    run_op(1'b0, 3'd1, 32'h102, 32'h0,        0, 32'h80FF7F01, 0, 32'hFFFF80FF, 32'h100, 4'b1100, 32'h0);
    run_op(1'b1, 3'd1, 32'h206, 32'h1234ABCD, 3, 32'h0,        0, 32'h0,        32'h204, 4'b1100, 32'hABCDABCD);
    run_op(1'b0, 3'd5, 32'h100, 32'h0,        2, 32'h80FF7F01, 0, 32'h00007F01, 32'h100, 4'b0011, 32'h0);
    run_op(1'b1, 3'd0, 32'h101, 32'h000000A5, 0, 32'h0,        0, 32'h0,        32'h100, 4'b0010, 32'hA5A5A5A5);
    run_op(1'b0, 3'd2, 32'h101, 32'h0,        0, 32'h0,        1, 32'h0,        32'h0,   4'b0000, 32'h0);
    run_op(1'b0, 3'd3, 32'h100, 32'h0,        0, 32'h0,        1, 32'h0,        32'h0,   4'b0000, 32'h0);
    run_op(1'b1, 3'd4, 32'h100, 32'h0,        0, 32'h0,        1, 32'h0,        32'h0,   4'b0000, 32'h0);
    run_op(1'b1, 3'd1, 32'h203, 32'h0,        0, 32'h0,        1, 32'h0,        32'h0,   4'b0000, 32'h0);
    tick();

    // Reset while waiting for load data; the late rvalid must be dropped.
    bus_q.push_back('{addr: 32'h300, be: 4'b1111, wdata: 32'h0, we: 1'b0});
    ex_valid = 1'b1; ex_we = 1'b0; ex_funct3 = 3'd2; ex_addr = 32'h300; ex_wdata = 32'h0;
    tick();
    ex_valid = 1'b0; mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("wait_busy", {31'd0, lsu_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_req",  {31'd0, mem_req},  32'd0);
    check("arst_busy", {31'd0, lsu_busy}, 32'd0);
    check("arst_wb",   {31'd0, wb_valid}, 32'd0);
    check("arst_dmem", dmem_out,          32'd0);
    check("arst_addr", mem_addr,          32'd0);
    model_dmem = 32'd0;
    tick();
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h55555555;
    tick();
    mem_rvalid = 1'b0;
    repeat (3) tick();
    check("stale_rvalid_dmem", dmem_out, 32'd0);

    // Back-to-back store then load with ex_valid held high.
    n = cyc;
    bus_q.push_back('{addr: 32'h10, be: 4'b1111, wdata: 32'h11223344, we: 1'b1});
    res_q.push_back('{fault: 1'b0, out: model_dmem, cyc: n + 2});
    ex_valid = 1'b1; ex_we = 1'b1; ex_funct3 = 3'd2; ex_addr = 32'h10; ex_wdata = 32'h11223344;
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("b2b_idle_at_wb", {31'd0, lsu_busy}, 32'd0);
    ex_we = 1'b0; ex_wdata = 32'h0;
    bus_q.push_back('{addr: 32'h10, be: 4'b1111, wdata: 32'h0, we: 1'b0});
    model_dmem = 32'hCAFEF00D;
    res_q.push_back('{fault: 1'b0, out: model_dmem, cyc: n + 5});
    tick();
    ex_valid = 1'b0; mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick();
    mem_rvalid = 1'b0;
    repeat (5) tick();

    check("bus_q_drained", bus_q.size(), 32'd0);
    check("res_q_drained", res_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit between the execute stage and the data-memory bus. It takes the ALU-computed address and the store operand from the register-file read port (rdata2), performs the bus transaction with a request/grant/response handshake, and returns byte/halfword-extended load data on `dmem_out` for the register-file write-back mux (WBSel = 0). It stalls the pipeline while a transaction is outstanding and flags misaligned or illegal accesses without touching the bus.

## Interface
- No parameters; address and data are fixed at 32 bits.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  memory operation present this cycle
- ex_we  in  1  1 = store, 0 = load
- ex_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU; SB/SH/SW)
- ex_addr  in  32  effective byte address (ALU_out)
- ex_wdata  in  32  store data (rdata2)
- lsu_busy  out  1  stall; high whenever state != IDLE
- dmem_out  out  32  extended load result
- wb_valid  out  1  one-cycle pulse: dmem_out valid / store complete
- lsu_fault  out  1  one-cycle pulse: misaligned or illegal funct3
- mem_req  out  1  bus request
- mem_we  out  1  bus write
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  load data valid
- mem_rdata  in  32  load word

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE: if ex_valid, check legality. Legal loads are funct3 0, 1, 2, 4, 5; legal stores are 0, 1, 2. Alignment: halfword needs addr[0]=0; word needs addr[1:0]=0.
  - Illegal or misaligned: next cycle lsu_fault=1 for one cycle, no bus activity, stay IDLE.
  - Legal: register we, funct3, addr[1:0], mem_addr, mem_be, mem_wdata; go to REQ.
- Byte enables: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111.
- Store data: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
- REQ: mem_req=1, with all bus outputs held stable until mem_gnt.
  - On gnt, a store goes to IDLE with a wb_valid pulse in the next cycle; dmem_out is unchanged.
  - On gnt, a load goes to WAIT.
- WAIT: on mem_rvalid, select the lane by the registered addr[1:0] and extend. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through. Register the result into dmem_out, pulse wb_valid, go to IDLE.
- ex_valid is ignored outside IDLE. mem_rvalid is ignored outside WAIT.

## Timing
- Reset values: state=IDLE; mem_req, mem_we, wb_valid, lsu_fault, lsu_busy = 0; mem_addr, mem_be, mem_wdata, dmem_out = 0.
- Reset mid-transaction: all outputs return to reset values immediately. A stale rvalid arriving later is dropped because the FSM is in IDLE.
- Accept (cycle 0) → mem_req high from cycle 1.
- Zero-wait bus (gnt in cycle 1, rvalid in cycle 2): load result and wb_valid appear in cycle 3. A store's wb_valid appears in cycle 2.
- mem_rvalid never arrives in the same cycle as mem_gnt. The bus guarantees this; the LSU does not sample rvalid in REQ.
- lsu_busy is registered (state != IDLE). The execute stage must hold its operation while busy. Back-to-back operations: the next ex_valid is accepted in the cycle wb_valid is high (state is IDLE then).
- wb_valid and lsu_fault are never high together.

## Test plan
- LW at 0x100, gnt in cycle 1, rvalid in cycle 2 with rdata 0xDEADBEEF → mem_addr=0x100, mem_be=4'b1111, mem_we=0; dmem_out=0xDEADBEEF with wb_valid in cycle 3.
- LB and LBU at 0x103, rdata 0x80FF7F01 → be=4'b1000; LB gives 0xFFFFFF80, LBU gives 0x00000080. LH at 0x102 on the same word → 0xFFFF80FF.
- SH at 0x206, wdata 0x1234ABCD, gnt held low 3 cycles → mem_req and bus fields stable through the stall; mem_addr=0x204, be=4'b1100, mem_wdata=0xABCDABCD, mem_we=1; wb_valid one cycle after gnt.
- LW at 0x101, then funct3=3 load at 0x100 → lsu_fault pulses once for each, mem_req stays 0, lsu_busy stays 0.
- rst_n low while in WAIT, rvalid arriving afterwards → mem_req=0 immediately, no wb_valid, dmem_out=0.
- Back-to-back SW then LW with ex_valid held high → the second operation is accepted exactly in the store's wb_valid cycle and completes correctly.
